// File: rtl/unified_buffer_sdp.sv
// Simple dual-port word buffer with per-lane write strobes and a hardware clear sequencer.
// Optional macro UB_RD_BYPASS_EN makes same-address read/write collisions write-first.
module unified_buffer_sdp #(
  parameter int DATA_LANES = 16,
  parameter int LANE_W     = 8,
  parameter int DEPTH      = 256,
  parameter int OUT_REG    = 0,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int WORD_W    = DATA_LANES * LANE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  wea,
  input  logic [DATA_LANES-1:0] wstrb,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [WORD_W-1:0]     dina,
  input  logic                  enb,
  input  logic [ADDR_W-1:0]     addrb,
  output logic [WORD_W-1:0]     doutb,
  output logic                  doutb_valid
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                idle;
  logic                rd_fire;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0]     wr_addr_d;
  logic [WORD_W-1:0]     wr_data_d;
  logic [DATA_LANES-1:0] wr_lanes_d;
  logic [WORD_W-1:0]     rd_word;

  logic [WORD_W-1:0]     data1_q;
  logic                  valid1_q;

  assign idle    = (state_q == IDLE);
  assign busy    = (state_q == CLEAR);
  assign rd_fire = idle && enb;

  // Reset parks the sequencer in CLEAR so the array is zeroed right after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The clear sequencer owns the write port while busy; user writes are dropped.
  always_comb begin
    wr_addr_d  = addra;
    wr_data_d  = dina;
    wr_lanes_d = '0;
    if (!idle) begin
      wr_addr_d  = clr_cnt_q;
      wr_data_d  = '0;
      wr_lanes_d = '1;
    end else if (wea) begin
      wr_lanes_d = wstrb;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_LANES; i++) begin
      if (wr_lanes_d[i]) begin
        mem[wr_addr_d][i*LANE_W +: LANE_W] <= wr_data_d[i*LANE_W +: LANE_W];
      end
    end
  end

`ifdef UB_RD_BYPASS_EN
  // Write-first: strobed lanes of a same-cycle write to the read address win.
  always_comb begin
    rd_word = mem[addrb];
    if (idle && wea && (addra == addrb)) begin
      for (int i = 0; i < DATA_LANES; i++) begin
        if (wstrb[i]) begin
          rd_word[i*LANE_W +: LANE_W] = dina[i*LANE_W +: LANE_W];
        end
      end
    end
  end
`else
  assign rd_word = mem[addrb];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= rd_fire;
      if (rd_fire) begin
        data1_q <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WORD_W-1:0] data2_q;
      logic              valid2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data2_q  <= '0;
          valid2_q <= 1'b0;
        end else begin
          valid2_q <= valid1_q;
          if (valid1_q) begin
            data2_q <= data1_q;
          end
        end
      end

      assign doutb       = data2_q;
      assign doutb_valid = valid2_q;
    end else begin : g_no_out_reg
      assign doutb       = data1_q;
      assign doutb_valid = valid1_q;
    end
  endgenerate

endmodule

// File: tb/tb_unified_buffer_sdp.sv
// Scoreboard bench for unified_buffer_sdp: one instance per read-latency mode sharing stimulus,
// checked against a lane-level array model of the buffer.
module tb_unified_buffer_sdp;

  localparam int LANES = 16;
  localparam int LW    = 8;
  localparam int DEPTH = 256;
  localparam int WW    = LANES * LW;

  typedef struct {
    logic [WW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          clrStart;
  logic          wea;
  logic [15:0]   wstrb;
  logic [7:0]    addra;
  logic [WW-1:0] dina;
  logic          enb;
  logic [7:0]    addrb;

  logic          busy0, busy1;
  logic [WW-1:0] doutb0, doutb1;
  logic          doutbValid0, doutbValid1;

  logic [WW-1:0] refMem [DEPTH];
  exp_t          q0[$];
  exp_t          q1[$];
  exp_t          e0, e1;
  logic [WW-1:0] lastData0, lastData1;

  int unsigned   cycleCount = 0;
  int            checkCount = 0;
  int            errorCount = 0;

  unified_buffer_sdp #(.DATA_LANES(LANES), .LANE_W(LW), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .clr_start(clrStart), .busy(busy0),
    .wea(wea), .wstrb(wstrb), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb0), .doutb_valid(doutbValid0)
  );

  unified_buffer_sdp #(.DATA_LANES(LANES), .LANE_W(LW), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .clr_start(clrStart), .busy(busy1),
    .wea(wea), .wstrb(wstrb), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb1), .doutb_valid(doutbValid1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic zeroModel();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  // Drive one cycle of traffic on the idle buffer and predict its read response.
  task automatic applyStimulus(input logic we, input logic [15:0] strb, input logic [7:0] aA,
                               input logic [WW-1:0] din, input logic en, input logic [7:0] aB);
    logic [WW-1:0] expWord;
    @(negedge clk);
    wea = we; wstrb = strb; addra = aA; dina = din; enb = en; addrb = aB; clrStart = 1'b0;
    if (en) begin
      expWord = refMem[aB];
`ifdef UB_RD_BYPASS_EN
      if (we && aA == aB)
        for (int i = 0; i < LANES; i++)
          if (strb[i]) expWord[i*LW +: LW] = din[i*LW +: LW];
`endif
      q0.push_back('{data: expWord, cyc: cycleCount + 1});
      q1.push_back('{data: expWord, cyc: cycleCount + 2});
    end
    if (we)
      for (int i = 0; i < LANES; i++)
        if (strb[i]) refMem[aA][i*LW +: LW] = din[i*LW +: LW];
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b0, 8'h0);
  endtask

  // Counts negedges with busy high, starting at the current one; stops early at abortAt.
  task automatic countBusy(input int abortAt, output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) @(negedge clk);
      if (!busy0 && !busy1) break;
      if (busy0) n0++;
      if (busy1) n1++;
      if (abortAt != 0 && n0 == abortAt) break;
    end
  endtask

  task automatic checkResetState();
    checkOutput("reset_busy0", WW'(busy0), WW'(1));
    checkOutput("reset_busy1", WW'(busy1), WW'(1));
    checkOutput("reset_doutb0", doutb0, '0);
    checkOutput("reset_doutb1", doutb1, '0);
    checkOutput("reset_valid0", WW'(doutbValid0), '0);
    checkOutput("reset_valid1", WW'(doutbValid1), '0);
  endtask

  always @(negedge clk) begin
    if (rst) lastData0 = '0;
    else if (doutbValid0) begin
      if (q0.size() == 0) begin
        checkCount++; errorCount++;
        $display("[TB] FAIL unexpected_valid0: got valid=1, required 0 (cycle %0d)", cycleCount);
      end else begin
        e0 = q0.pop_front();
        checkOutput("data0", doutb0, e0.data);
        checkOutput("latency0", WW'(cycleCount), WW'(e0.cyc));
      end
      lastData0 = doutb0;
    end else checkOutput("hold0", doutb0, lastData0);
  end

  always @(negedge clk) begin
    if (rst) lastData1 = '0;
    else if (doutbValid1) begin
      if (q1.size() == 0) begin
        checkCount++; errorCount++;
        $display("[TB] FAIL unexpected_valid1: got valid=1, required 0 (cycle %0d)", cycleCount);
      end else begin
        e1 = q1.pop_front();
        checkOutput("data1", doutb1, e1.data);
        checkOutput("latency1", WW'(cycleCount), WW'(e1.cyc));
      end
      lastData1 = doutb1;
    end else checkOutput("hold1", doutb1, lastData1);
  end

  initial begin
    int n0, n1;
    logic [WW-1:0] word;
    rst = 1'b1; clrStart = 1'b0; wea = 1'b0; wstrb = '0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
    zeroModel();
    repeat (3) @(negedge clk);
    checkResetState();

    rst = 1'b0;
    countBusy(0, n0, n1);
    checkOutput("busy_len_after_reset0", WW'(n0), WW'(DEPTH));
    checkOutput("busy_len_after_reset1", WW'(n1), WW'(DEPTH));

    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'(a));
    idleCycles(3);

    applyStimulus(1'b1, 16'hFFFF, 8'd5, {LANES{8'hAA}}, 1'b0, 8'h0);
    applyStimulus(1'b1, 16'h0001, 8'd5, {LANES{8'h55}}, 1'b0, 8'h0);
    applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'd5);
    word = {{(LANES-1){8'hAA}}, 8'h55};
    checkOutput("strobe_model", refMem[5], word);
    idleCycles(3);

    for (int a = 0; a < 8; a++)
      applyStimulus(1'b1, 16'hFFFF, 8'(a), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 8'h0);
    for (int a = 0; a < 8; a++) applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'(a));
    idleCycles(3);

    applyStimulus(1'b1, 16'hFFFF, 8'd9, {LANES{8'h11}}, 1'b1, 8'd9);
    applyStimulus(1'b1, 16'h0000, 8'd9, {LANES{8'h77}}, 1'b1, 8'd9);
    idleCycles(3);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom()), 8'($urandom_range(0, 15)),
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
    idleCycles(3);

    // Clear with writes, reads and a second clr_start landing while busy.
    @(negedge clk);
    clrStart = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      clrStart = 1'b0; wea = 1'b0; enb = 1'b0; wstrb = '0;
      if (!busy0 && !busy1) break;
      if (busy0) n0++;
      if (busy1) n1++;
      if (n0 == 10 || n0 == 200) begin
        wea = 1'b1; wstrb = 16'hFFFF; addra = (n0 == 10) ? 8'd5 : 8'd0;
        dina = {$urandom(), $urandom(), $urandom(), $urandom()};
        enb = 1'b1; addrb = 8'd5;
      end
      if (n0 == 120) clrStart = 1'b1;
    end
    zeroModel();
    checkOutput("busy_len_interfered0", WW'(n0), WW'(DEPTH));
    checkOutput("busy_len_interfered1", WW'(n1), WW'(DEPTH));
    applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'd0);
    applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'd5);
    idleCycles(3);

    // Reset with a read in flight: that read must never complete.
    applyStimulus(1'b1, 16'hFFFF, 8'd3, {LANES{8'hC3}}, 1'b0, 8'h0);
    applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    enb = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    checkResetState();
    @(negedge clk);
    rst = 1'b0;
    countBusy(0, n0, n1);
    zeroModel();
    checkOutput("busy_len_flight_reset0", WW'(n0), WW'(DEPTH));

    // Reset part-way through the clear, once word 100 is next.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    countBusy(101, n0, n1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    countBusy(0, n0, n1);
    checkOutput("busy_len_midclear_reset0", WW'(n0), WW'(DEPTH));
    checkOutput("busy_len_midclear_reset1", WW'(n1), WW'(DEPTH));

    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'h0, 8'h0, '0, 1'b1, 8'($urandom_range(0, DEPTH-1)));
    idleCycles(5);
    checkOutput("queue0_drained", WW'(q0.size()), '0);
    checkOutput("queue1_drained", WW'(q1.size()), '0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/unified_buffer_sdp.md
UNIFIED_BUFFER_SDP -- requirements
Module: unified_buffer_sdp

Interface
REQ-001 SHALL have parameter DATA_LANES, default 16, meaning number of byte lanes per word.
REQ-002 SHALL have parameter LANE_W, default 8, meaning bits per lane.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of words; power of two, minimum 4.
REQ-004 SHALL have parameter OUT_REG, default 0, meaning 0 = 1-cycle read latency and 1 = 2-cycle read latency through an extra output register.
REQ-005 SHALL derive localparam ADDR_W = clog2(DEPTH) and WORD_W = DATA_LANES*LANE_W.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port clr_start, input, 1, a one-cycle request to zero the whole array.
REQ-009 SHALL have port busy, output, 1, high while the clear sequencer runs.
REQ-010 SHALL have port wea, input, 1, write enable.
REQ-011 SHALL have port wstrb, input, DATA_LANES, per-lane write strobe.
REQ-012 SHALL have port addra, input, ADDR_W, write address.
REQ-013 SHALL have port dina, input, WORD_W, write data; lane i = dina[i*LANE_W +: LANE_W].
REQ-014 SHALL have port enb, input, 1, read enable.
REQ-015 SHALL have port addrb, input, ADDR_W, read address.
REQ-016 SHALL have port doutb, output, WORD_W, registered read data.
REQ-017 SHALL have port doutb_valid, output, 1, high for exactly one cycle per accepted read, aligned with doutb.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and CLEAR.
- CLEAR: writes zero to word clr_cnt each cycle, with clr_cnt counting 0..DEPTH-1.
- CLEAR->IDLE: after writing word DEPTH-1.
- IDLE->CLEAR: on clr_start.
REQ-019 SHALL drive busy=1 in CLEAR and 0 in IDLE.
- A clear takes exactly DEPTH cycles.
- busy falls on the edge after word DEPTH-1 is written.
REQ-020 SHALL ignore clr_start while in CLEAR: no restart, no extension.
REQ-021 SHALL ignore wea and enb while busy=1: no write, and doutb_valid is not asserted for reads issued in that cycle.
REQ-022 SHALL, on an IDLE cycle with wea=1, update only the lanes whose wstrb bit is set; other lanes keep their value; wstrb=0 is a legal no-op.
REQ-023 SHALL, on an IDLE cycle with enb=1, present mem[addrb] on doutb and doutb_valid=1:
- one edge later when OUT_REG=0;
- two edges later when OUT_REG=1.
REQ-024 SHALL hold doutb at its last value when no read completes; doutb_valid=0 in that cycle.
REQ-025 SHALL accept back-to-back reads every cycle at full throughput in both latency modes.
REQ-026 SHALL, without UB_RD_BYPASS_EN, be read-first on a same-cycle read and write to the same address: doutb returns the pre-write word.
REQ-027 SHALL treat addresses as exactly ADDR_W bits, so there is no out-of-range access.

Reset
REQ-028 SHALL, while rst=1, force:
- doutb=0
- doutb_valid=0, including the OUT_REG pipeline stage
- clr_cnt=0
- FSM=CLEAR, so busy=1
REQ-029 SHALL begin the clear sequence on the first rising edge after rst deasserts, and be IDLE DEPTH cycles later.
REQ-030 SHALL abandon the current sequence when rst asserts mid-clear, and restart from word 0 after release.
REQ-031 SHALL drop any read in flight when rst asserts; no doutb_valid after release for that read.

Configuration
REQ-032 SHALL, with macro UB_RD_BYPASS_EN defined, be write-first on a same-cycle same-address read and write:
- strobed lanes of doutb take dina;
- unstrobed lanes take the stored word;
- latency and doutb_valid timing are unchanged.
REQ-033 SHALL, with UB_RD_BYPASS_EN undefined, contain no bypass logic and behave per REQ-026.

Verification
REQ-034 SHALL cover reset-then-clear: after rst release, check busy=1 for exactly 256 cycles, then read all 256 addresses -> every doutb=0 with doutb_valid=1.
REQ-035 SHALL cover lane strobes:
- write addr 5, dina all 0xAA, wstrb=0xFFFF;
- then write addr 5, dina all 0x55, wstrb=0x0001;
- read addr 5 -> lane0=0x55, lanes1..15=0xAA.
REQ-036 SHALL cover latency: with OUT_REG=0 and OUT_REG=1, issue reads on addresses 0..7 on consecutive cycles -> doutb_valid contiguous for 8 cycles, starting 1 or 2 cycles after the first enb respectively, with data in order.
REQ-037 SHALL cover collision: after addr 9 is cleared, write 0x11 in all lanes to addr 9 while reading addr 9 in the same cycle -> doutb=0 without the macro, doutb=all 0x11 with UB_RD_BYPASS_EN.
REQ-038 SHALL cover clear interference:
- pulse clr_start, then assert wea and enb during busy -> no array change and doutb_valid stays 0;
- pulse clr_start again mid-clear -> busy length still 256.
REQ-039 SHALL cover reset mid-clear: assert rst at clr_cnt=100 -> after release, busy lasts a full 256 cycles; with a read in flight at rst, no doutb_valid appears after release.
